// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage and its buffer FIFO.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned DEPTH_DEFAULT    = 2;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instruction;
    } fetch_entry_t;

    function automatic logic [31:0] pc_plus4(input logic [31:0] pc);
        return pc + 32'd4;
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Handshake bundle between the fetch stage, instruction memory, branch unit and decode.
interface fetch_stage_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instruction;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output id_valid, id_instruction, id_pc, id_pc_plus4,
        input  id_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  id_valid, id_instruction, id_pc, id_pc_plus4,
        output id_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Circular buffer of fetched {pc, instruction} entries with flush and occupancy count.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    localparam int unsigned CW = $clog2(DEPTH + 1),
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_data,
    output fetch_entry_t head,
    output logic [CW-1:0] count
);

    fetch_entry_t  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          pop_s;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(DEPTH - 1)) begin
            return '0;
        end else begin
            return p + PW'(1);
        end
    endfunction

    // Never pop an empty buffer even if the consumer misbehaves.
    assign pop_s = pop && (count_r != CW'(0));
    assign head  = mem_r[rd_ptr_r];
    assign count = count_r;

    // Storage, pointers and occupancy; flush wins over same-cycle push/pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            case ({push, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// In-order instruction fetch with redirect/drain handling and a small decode buffer.
// Optional FETCH_STATS_EN adds stat_fetched / stat_bubbles counters.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned DEPTH    = DEPTH_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    fetch_stage_if.master bus
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]   stat_fetched,
    output logic [31:0]   stat_bubbles
`endif
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_e  state_r, state_nx_s;
    logic [31:0]   fetch_pc_r;
    logic [31:0]   rsp_pc_r;
    logic [CW-1:0] outstanding_r, outstanding_nx_s;
    logic [CW-1:0] discard_r, discard_nx_s;
    logic [CW-1:0] count_s, count_nx_s;
    logic [CW:0]   occ_nx_s;
    logic          req_ok_r, req_ok_nx_s;
    logic          fire_s, pop_s, keep_s, id_valid_s;
    fetch_entry_t  head_s, push_data_s;

    assign fire_s      = bus.imem_req_valid && bus.imem_req_ready;
    assign id_valid_s  = (count_s != CW'(0));
    assign pop_s       = id_valid_s && bus.id_ready;
    assign keep_s      = bus.imem_rsp_valid && !bus.redirect_valid && (state_r == RUN);
    assign push_data_s = '{pc: rsp_pc_r, instruction: bus.imem_rsp_data};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (keep_s),
        .pop       (pop_s),
        .flush     (bus.redirect_valid),
        .push_data (push_data_s),
        .head      (head_s),
        .count     (count_s)
    );

    // Request permission is precomputed from next-cycle occupancy; only redirect gates it live.
    assign bus.imem_req_valid = req_ok_r && !bus.redirect_valid;
    assign bus.imem_req_addr  = fetch_pc_r;
    assign bus.id_valid       = id_valid_s;
    assign bus.id_instruction = id_valid_s ? head_s.instruction : 32'h0;
    assign bus.id_pc          = id_valid_s ? head_s.pc : 32'h0;
    assign bus.id_pc_plus4    = id_valid_s ? pc_plus4(head_s.pc) : 32'h0;

    // Next-state of occupancy, discard bookkeeping and FSM.
    always_comb begin
        outstanding_nx_s = outstanding_r;
        count_nx_s       = count_s;
        state_nx_s       = state_r;
        discard_nx_s     = discard_r;

        case ({fire_s, bus.imem_rsp_valid})
            2'b10:   outstanding_nx_s = outstanding_r + CW'(1);
            2'b01:   outstanding_nx_s = outstanding_r - CW'(1);
            default: outstanding_nx_s = outstanding_r;
        endcase

        if (bus.redirect_valid) begin
            count_nx_s = '0;
        end else begin
            case ({keep_s, pop_s})
                2'b10:   count_nx_s = count_s + CW'(1);
                2'b01:   count_nx_s = count_s - CW'(1);
                default: count_nx_s = count_s;
            endcase
        end

        if (bus.redirect_valid) begin
            // Everything still in flight after this cycle belongs to the abandoned path.
            discard_nx_s = outstanding_nx_s;
            state_nx_s   = (outstanding_nx_s != CW'(0)) ? DRAIN : RUN;
        end else begin
            case (state_r)
                INIT: state_nx_s = RUN;
                RUN:  state_nx_s = RUN;
                DRAIN: begin
                    if (bus.imem_rsp_valid && (discard_r != CW'(0))) begin
                        discard_nx_s = discard_r - CW'(1);
                        state_nx_s   = (discard_r == CW'(1)) ? RUN : DRAIN;
                    end else begin
                        state_nx_s   = (discard_r == CW'(0)) ? RUN : DRAIN;
                    end
                end
                default: state_nx_s = INIT;
            endcase
        end

        occ_nx_s    = (CW + 1)'(outstanding_nx_s) + (CW + 1)'(count_nx_s);
        req_ok_nx_s = (state_nx_s == RUN) && (occ_nx_s < (CW + 1)'(DEPTH));
    end

    // Architectural fetch state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= INIT;
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= '0;
            discard_r     <= '0;
            req_ok_r      <= 1'b0;
        end else begin
            state_r       <= state_nx_s;
            outstanding_r <= outstanding_nx_s;
            discard_r     <= discard_nx_s;
            req_ok_r      <= req_ok_nx_s;
            if (bus.redirect_valid) begin
                fetch_pc_r <= bus.redirect_pc;
                rsp_pc_r   <= bus.redirect_pc;
            end else begin
                if (fire_s) begin
                    fetch_pc_r <= pc_plus4(fetch_pc_r);
                end
                if (keep_s) begin
                    rsp_pc_r <= pc_plus4(rsp_pc_r);
                end
            end
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched_r;
    logic [31:0] stat_bubbles_r;

    // Delivered-instruction and decode-starvation counters, free-running modulo 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched_r <= 32'h0;
            stat_bubbles_r <= 32'h0;
        end else begin
            if (pop_s) begin
                stat_fetched_r <= stat_fetched_r + 32'd1;
            end
            if (bus.id_ready && !id_valid_s) begin
                stat_bubbles_r <= stat_bubbles_r + 32'd1;
            end
        end
    end

    assign stat_fetched = stat_fetched_r;
    assign stat_bubbles = stat_bubbles_r;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected PCs are queued by stimulus, a monitor checks each pop.
module tb_fetch_stage;
    import fetch_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if bus ();
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_bubbles;
`endif

    fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_bubbles (stat_bubbles)
`endif
    );

    typedef struct { int unsigned due; logic [31:0] addr; } mem_req_t;

    int          checks = 0;
    int          errors = 0;
    int          delivered = 0;
    int          target = 0;
    int          fires = 0;
    int unsigned cyc = 0;
    int unsigned mem_lat = 1;
    logic        dec_en = 1'b0;
    logic [31:0] exp_q [$];
    mem_req_t    mq [$];

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    // Instruction memory: in-order responses mem_lat cycles after acceptance.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = 32'h0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                mq.delete();
                fires = 0;
            end else if (bus.imem_req_valid && bus.imem_req_ready) begin
                mq.push_back('{due: cyc + mem_lat, addr: bus.imem_req_addr});
                fires++;
            end
            @(posedge clk);
            #1;
            cyc++;
            if (rst_n && mq.size() > 0 && mq[0].due <= cyc) begin
                bus.imem_rsp_valid = 1'b1;
                bus.imem_rsp_data  = instr_of(mq[0].addr);
                void'(mq.pop_front());
            end else begin
                bus.imem_rsp_valid = 1'b0;
            end
        end
    end

    // Decode side: accept until the requested number of instructions has been taken.
    initial begin
        bus.id_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            bus.id_ready = dec_en && (delivered < target);
        end
    end

    // Monitor: every pop is compared against the head of the expected queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                delivered = 0;
            end else if (bus.id_valid && bus.id_ready) begin
                delivered++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pop: actual pc %h required no delivery", bus.id_pc);
                end else begin
                    e = exp_q.pop_front();
                    check("id_pc", bus.id_pc, e);
                    check("id_instruction", bus.id_instruction, instr_of(e));
                    check("id_pc_plus4", bus.id_pc_plus4, e + 32'd4);
                end
            end
        end
    end

    task automatic do_reset(input int unsigned lat);
        @(posedge clk);
        #3;
        rst_n              = 1'b0;
        dec_en             = 1'b0;
        target             = 0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.imem_req_ready = 1'b1;
        mem_lat            = lat;
        exp_q.delete();
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        check("rst_id_valid", {31'h0, bus.id_valid}, 32'h0);
        check("rst_id_pc", bus.id_pc, 32'h0);
        check("rst_id_instruction", bus.id_instruction, 32'h0);
        check("rst_id_pc_plus4", bus.id_pc_plus4, 32'h0);
`ifdef FETCH_STATS_EN
        check("rst_stat_fetched", stat_fetched, 32'h0);
        check("rst_stat_bubbles", stat_bubbles, 32'h0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("init_req_valid", {31'h0, bus.imem_req_valid}, 32'h0);
        @(negedge clk);
        #1;
        check("run_req_valid", {31'h0, bus.imem_req_valid}, 32'h1);
        check("run_req_addr", bus.imem_req_addr, 32'h0);
    endtask

    task automatic push_exp(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(base + 32'(4 * i));
        end
    endtask

    task automatic wait_done(input string name);
        for (int i = 0; i < 300 && delivered < target; i++) begin
            @(negedge clk);
            #1;
        end
        repeat (2) @(negedge clk);
        #1;
        check({name, "_delivered"}, 32'(delivered), 32'(target));
        check({name, "_exp_left"}, 32'(exp_q.size()), 32'h0);
    endtask

    initial begin
        logic found;
        bus.imem_req_ready = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;

        // Streaming fetch, always-ready memory and decode.
        do_reset(1);
        push_exp(32'h0, 8);
        target = 8;
        dec_en = 1'b1;
        wait_done("stream");

        // Decode stalled for 10 cycles, then released.
        do_reset(1);
        repeat (10) begin
            @(negedge clk);
            #1;
            if (bus.id_valid) check("stall_id_pc", bus.id_pc, 32'h0);
        end
        check("stall_fires_le2", (fires <= 2) ? 32'h1 : 32'h0, 32'h1);
        check("stall_id_valid", {31'h0, bus.id_valid}, 32'h1);
        push_exp(32'h0, 4);
        target = 4;
        dec_en = 1'b1;
        wait_done("stall");

        // Memory back-pressure while the third address is pending.
        do_reset(1);
        push_exp(32'h0, 6);
        target = 6;
        dec_en = 1'b1;
        for (int i = 0; i < 50 && fires < 2; i++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #2;
        bus.imem_req_ready = 1'b0;
        repeat (3) begin
            @(negedge clk);
            #1;
            check("bp_req_addr", bus.imem_req_addr, 32'h8);
        end
        @(posedge clk);
        #2;
        bus.imem_req_ready = 1'b1;
        wait_done("backpressure");

        // Redirect with two requests in flight (3-cycle memory).
        do_reset(3);
        push_exp(32'h100, 3);
        target = 3;
        dec_en = 1'b1;
        for (int i = 0; i < 50 && fires < 2; i++) begin
            @(negedge clk);
            #1;
        end
        @(posedge clk);
        #2;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        @(negedge clk);
        #1;
        check("redir_req_blocked", {31'h0, bus.imem_req_valid}, 32'h0);
        @(posedge clk);
        #2;
        bus.redirect_valid = 1'b0;
        wait_done("redirect");

        // Redirect in the same cycle as a response and a pop.
        do_reset(1);
        exp_q.push_back(32'h0);
        push_exp(32'h200, 2);
        target = 3;
        dec_en = 1'b1;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(posedge clk);
            #2;
            if (bus.imem_rsp_valid && bus.id_valid && bus.id_ready) found = 1'b1;
        end
        check("coincide_found", {31'h0, found}, 32'h1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0200;
        @(posedge clk);
        #2;
        bus.redirect_valid = 1'b0;
        @(negedge clk);
        #1;
        check("coincide_fifo_empty", {31'h0, bus.id_valid}, 32'h0);
        wait_done("coincide");

        // Five deliveries with natural bubbles after reset.
        do_reset(1);
        push_exp(32'h0, 5);
        target = 5;
        dec_en = 1'b1;
        wait_done("stats");
`ifdef FETCH_STATS_EN
        check("stat_fetched", stat_fetched, 32'd5);
        check("stat_bubbles", stat_bubbles, 32'd3);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
